// File: rtl/lsu_stage_if.sv
// Signal bundle between the load/store stage and its neighbours: EXU input side,
// data-memory req/gnt/rvalid bus and writeback output side.
interface lsu_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 5
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic [DATA_WIDTH-1:0] RD2;
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            Funct3;
    logic                  RegWrite_in;
    logic [RD_WIDTH-1:0]   Rd_in;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_WIDTH-1:0] WBData;
    logic                  RegWrite_out;
    logic [RD_WIDTH-1:0]   Rd_out;
    logic                  Misalign;

    // The stage itself.
    modport slave (
        input  ex_valid, ALUResult, RD2, MemRead, MemWrite, Funct3, RegWrite_in, Rd_in,
               mem_gnt, mem_rvalid, mem_rdata, wb_ready,
        output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_valid, WBData, RegWrite_out, Rd_out, Misalign
    );

    // The surrounding pipeline and memory.
    modport master (
        output ex_valid, ALUResult, RD2, MemRead, MemWrite, Funct3, RegWrite_in, Rd_in,
               mem_gnt, mem_rvalid, mem_rdata, wb_ready,
        input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_valid, WBData, RegWrite_out, Rd_out, Misalign
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage between EXU and WBU: one data-memory transaction per instruction,
// load lane select and extension, single registered result towards writeback.
module lsu_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 5
) (
    input logic        clk,
    input logic        rstn,
    lsu_stage_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0] wbdata_q, wbdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic                  store_q, store_d;
    logic                  regwrite_q, regwrite_d;
    logic                  misalign_q, misalign_d;

    logic                  in_mem;
    logic                  in_misalign;
    logic                  in_req;
    logic                  in_done;
    logic [3:0]            strb;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [DATA_WIDTH-1:0] load_data;

    // Access size comes from Funct3[1:0]; the unused codes behave as word.
    always_comb begin
        in_mem = bus.MemRead | bus.MemWrite;
        case (bus.Funct3[1:0])
            2'b00:   in_misalign = 1'b0;
            2'b01:   in_misalign = bus.ALUResult[0];
            default: in_misalign = |bus.ALUResult[1:0];
        endcase
        in_misalign = in_misalign & in_mem;
    end

    always_comb begin
        strb       = 4'b1111;
        lane_wdata = rd2_q;
        case (funct3_q[1:0])
            2'b00: begin
                strb       = 4'b0001 << alu_q[1:0];
                lane_wdata = {4{rd2_q[7:0]}};
            end
            2'b01: begin
                strb       = alu_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{rd2_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Funct3[2] set means the unsigned variant.
    always_comb begin
        rdata_shift = bus.mem_rdata >> {alu_q[1:0], 3'b000};
        case (funct3_q[1:0])
            2'b00: load_data = funct3_q[2]
                ? {{(DATA_WIDTH-8){1'b0}}, rdata_shift[7:0]}
                : {{(DATA_WIDTH-8){rdata_shift[7]}}, rdata_shift[7:0]};
            2'b01: load_data = funct3_q[2]
                ? {{(DATA_WIDTH-16){1'b0}}, rdata_shift[15:0]}
                : {{(DATA_WIDTH-16){rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alu_d      = alu_q;
        rd2_d      = rd2_q;
        wbdata_d   = wbdata_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        store_d    = store_q;
        regwrite_d = regwrite_q;
        misalign_d = misalign_q;
        case (state_q)
            StIdle: begin
                if (bus.ex_valid) begin
                    alu_d      = bus.ALUResult;
                    rd2_d      = bus.RD2;
                    funct3_d   = bus.Funct3;
                    rd_d       = bus.Rd_in;
                    store_d    = bus.MemWrite;
                    misalign_d = in_misalign;
                    regwrite_d = bus.RegWrite_in & ~in_misalign & ~bus.MemWrite;
                    wbdata_d   = bus.ALUResult;
                    state_d    = (in_misalign || !in_mem) ? StDone : StReq;
                end
            end
            StReq: begin
                if (bus.mem_gnt) begin
                    state_d = store_q ? StDone : StResp;
                end
            end
            StResp: begin
                if (bus.mem_rvalid) begin
                    wbdata_d = load_data;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (bus.wb_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            alu_q      <= '0;
            rd2_q      <= '0;
            wbdata_q   <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            store_q    <= 1'b0;
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_q      <= alu_d;
            rd2_q      <= rd2_d;
            wbdata_q   <= wbdata_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            store_q    <= store_d;
            regwrite_q <= regwrite_d;
            misalign_q <= misalign_d;
        end
    end

    assign in_req  = (state_q == StReq);
    assign in_done = (state_q == StDone);

    assign bus.ex_ready     = (state_q == StIdle);
    assign bus.mem_req      = in_req;
    assign bus.mem_we       = in_req & store_q;
    assign bus.mem_addr     = in_req ? {alu_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_wdata    = (in_req && store_q) ? lane_wdata : '0;
    assign bus.mem_wstrb    = (in_req && store_q) ? strb : 4'b0000;
    assign bus.wb_valid     = in_done;
    assign bus.WBData       = wbdata_q;
    assign bus.RegWrite_out = in_done & regwrite_q;
    assign bus.Rd_out       = rd_q;
    assign bus.Misalign     = in_done & misalign_q;
endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: directed vector table, random instructions against a
// behavioural model, and asynchronous-reset sequences.
module tb_lsu_stage;
    localparam int DW = 32;
    localparam int RW = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lsu_stage_if #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) bus ();

    lsu_stage #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] alu, rd2, rdata;
        logic        mr, mw;
        logic [2:0]  f3;
        logic        rw;
        logic [4:0]  rd;
        logic        rvg;   // also pulse rvalid (with wrong data) in the gnt cycle
    } instr_t;

    typedef struct {
        int          reqc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] wbdata;
        logic        rw;
        logic [4:0]  rdo;
        logic        mis;
        int          wb_at;
        logic        unstable;
        logic        busy_ready;
        logic        timeout;
    } obs_t;

    typedef struct {
        string  name;
        instr_t ins;
        int     gd, rv, wbd;
        obs_t   exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic instr_t mi(input logic [31:0] alu, input logic [31:0] rd2,
                                  input logic [31:0] rdata, input logic mr, input logic mw,
                                  input logic [2:0] f3, input logic rw, input logic [4:0] rd,
                                  input logic rvg);
        instr_t i;
        i.alu = alu; i.rd2 = rd2; i.rdata = rdata; i.mr = mr; i.mw = mw;
        i.f3 = f3; i.rw = rw; i.rd = rd; i.rvg = rvg;
        return i;
    endfunction

    function automatic obs_t mo(input int reqc, input logic [31:0] addr, input logic we,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic [31:0] wbdata, input logic rw, input logic [4:0] rdo,
                                input logic mis, input int wb_at);
        obs_t o;
        o = '{default: 0};
        o.reqc = reqc; o.addr = addr; o.we = we; o.wdata = wdata; o.wstrb = wstrb;
        o.wbdata = wbdata; o.rw = rw; o.rdo = rdo; o.mis = mis; o.wb_at = wb_at;
        return o;
    endfunction

    task automatic add_vec(input string nm, input instr_t i, input int gd, input int rv,
                           input int wbd, input obs_t e);
        vec_t v;
        v.name = nm; v.ins = i; v.gd = gd; v.rv = rv; v.wbd = wbd; v.exp = e;
        vecs.push_back(v);
    endtask

    // Behavioural reference: byte-lane arithmetic straight from the access rules.
    function automatic obs_t model(input instr_t i, input int gd, input int rv);
        obs_t        e;
        int          sz;
        int          off;
        logic [63:0] v, m;
        e = '{default: 0};
        sz  = (i.f3[1:0] == 2'b00) ? 1 : (i.f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(i.alu % 4);
        e.rdo    = i.rd;
        e.wbdata = i.alu;
        e.wb_at  = 1;
        if (!(i.mr || i.mw)) begin
            e.rw = i.rw;
            return e;
        end
        if ((off % sz) != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.reqc = gd + 1;
        e.addr = i.alu - 32'(off);
        if (i.mw) begin
            e.we    = 1'b1;
            e.wb_at = gd + 2;
            e.wstrb = 4'(((1 << sz) - 1) << off);
            for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = 8'(i.rd2 >> (8 * (k % sz)));
        end else begin
            e.rw    = i.rw;
            e.wb_at = gd + rv + 2;
            v = 64'(i.rdata) >> (8 * off);
            m = (64'd1 << (8 * sz)) - 64'd1;
            v = v & m;
            if (sz < 4 && !i.f3[2] && v[8*sz-1]) v = v | ~m;
            e.wbdata = v[31:0];
        end
        return e;
    endfunction

    // Issue one instruction at a negedge with the DUT idle, act as memory and WBU.
    task automatic run_instr(input string nm, input instr_t ins, input int gd, input int rv,
                             input int wbd, output obs_t o);
        bit granted = 0;
        bit fin     = 0;
        int since   = 0;
        int wbc     = 0;
        o = '{default: 0};
        check({nm, ".ex_ready_idle"}, 64'(bus.ex_ready), 64'd1);
        bus.ex_valid    = 1'b1;
        bus.ALUResult   = ins.alu;
        bus.RD2         = ins.rd2;
        bus.MemRead     = ins.mr;
        bus.MemWrite    = ins.mw;
        bus.Funct3      = ins.f3;
        bus.RegWrite_in = ins.rw;
        bus.Rd_in       = ins.rd;
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid    = 1'b0;
        bus.ALUResult   = $urandom;
        bus.RD2         = $urandom;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.Funct3      = 3'($urandom);
        bus.RegWrite_in = 1'($urandom);
        bus.Rd_in       = 5'($urandom);
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.wb_ready   = 1'b0;
            if (bus.ex_ready) o.busy_ready = 1'b1;
            if (bus.mem_req) begin
                if (o.reqc == 0) begin
                    o.addr = bus.mem_addr; o.we = bus.mem_we;
                    o.wdata = bus.mem_wdata; o.wstrb = bus.mem_wstrb;
                end else if (o.addr !== bus.mem_addr || o.we !== bus.mem_we ||
                             o.wdata !== bus.mem_wdata || o.wstrb !== bus.mem_wstrb) begin
                    o.unstable = 1'b1;
                end
                o.reqc++;
                if (o.reqc > gd) begin
                    bus.mem_gnt = 1'b1;
                    granted     = 1;
                    since       = 0;
                    if (ins.rvg) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = ~ins.rdata;
                    end
                end
            end else if (granted) begin
                since++;
                if (since == rv) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = ins.rdata;
                end
            end
            if (bus.wb_valid) begin
                if (wbc == 0) begin
                    o.wb_at = cyc; o.wbdata = bus.WBData; o.rw = bus.RegWrite_out;
                    o.rdo = bus.Rd_out; o.mis = bus.Misalign;
                end else if (o.wbdata !== bus.WBData || o.rw !== bus.RegWrite_out ||
                             o.rdo !== bus.Rd_out || o.mis !== bus.Misalign) begin
                    o.unstable = 1'b1;
                end
                wbc++;
                if (wbc > wbd) begin
                    bus.wb_ready = 1'b1;
                    fin          = 1;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.wb_ready   = 1'b0;
        o.timeout      = !fin;
    endtask

    task automatic compare_obs(input string nm, input obs_t g, input obs_t e);
        check({nm, ".timeout"}, 64'(g.timeout), 64'd0);
        check({nm, ".req_cycles"}, 64'(g.reqc), 64'(e.reqc));
        check({nm, ".wb_latency"}, 64'(g.wb_at), 64'(e.wb_at));
        check({nm, ".WBData"}, 64'(g.wbdata), 64'(e.wbdata));
        check({nm, ".RegWrite_out"}, 64'(g.rw), 64'(e.rw));
        check({nm, ".Rd_out"}, 64'(g.rdo), 64'(e.rdo));
        check({nm, ".Misalign"}, 64'(g.mis), 64'(e.mis));
        check({nm, ".stable"}, 64'(g.unstable), 64'd0);
        check({nm, ".ex_ready_busy"}, 64'(g.busy_ready), 64'd0);
        if (e.reqc > 0) begin
            check({nm, ".mem_addr"}, 64'(g.addr), 64'(e.addr));
            check({nm, ".mem_we"}, 64'(g.we), 64'(e.we));
            check({nm, ".mem_wstrb"}, 64'(g.wstrb), 64'(e.wstrb));
            if (e.we) check({nm, ".mem_wdata"}, 64'(g.wdata), 64'(e.wdata));
        end
    endtask

    initial begin
        obs_t       got;
        obs_t       exp;
        instr_t     r;
        logic [2:0] codes [8];
        bit         saw_wb;

        bus.ex_valid = 0; bus.ALUResult = 0; bus.RD2 = 0; bus.MemRead = 0; bus.MemWrite = 0;
        bus.Funct3 = 0; bus.RegWrite_in = 0; bus.Rd_in = 0; bus.mem_gnt = 0;
        bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.wb_ready = 0;

        // name, {alu, rd2, rdata, mr, mw, f3, rw, rd, rvg}, gnt delay, rvalid delay, wb stall,
        // {reqc, addr, we, wdata, wstrb, WBData, RegWrite_out, Rd_out, Misalign, wb latency}
        add_vec("nonmem", mi(32'h1234, 0, 0, 0, 0, 3'b000, 1, 5'd5, 0), 0, 1, 0,
                mo(0, 0, 0, 0, 0, 32'h1234, 1, 5'd5, 0, 1));
        add_vec("lb_bp", mi(32'h1003, 0, 32'h80FF_FFFF, 1, 0, 3'b000, 1, 5'd7, 0), 0, 1, 5,
                mo(1, 32'h1000, 0, 0, 0, 32'hFFFF_FF80, 1, 5'd7, 0, 3));
        add_vec("lbu", mi(32'h1003, 0, 32'h80FF_FFFF, 1, 0, 3'b100, 1, 5'd8, 0), 0, 1, 0,
                mo(1, 32'h1000, 0, 0, 0, 32'h0000_0080, 1, 5'd8, 0, 3));
        add_vec("sh_wait", mi(32'h2002, 32'hABCD_1234, 0, 0, 1, 3'b001, 1, 5'd9, 0), 3, 1, 0,
                mo(4, 32'h2000, 1, 32'h1234_1234, 4'b1100, 32'h2002, 0, 5'd9, 0, 5));
        add_vec("lw_mis", mi(32'h3001, 0, 0, 1, 0, 3'b010, 1, 5'd3, 0), 0, 1, 0,
                mo(0, 0, 0, 0, 0, 32'h3001, 0, 5'd3, 1, 1));
        add_vec("lh_hi", mi(32'h1002, 0, 32'h8001_7FFF, 1, 0, 3'b001, 1, 5'd10, 0), 0, 1, 0,
                mo(1, 32'h1000, 0, 0, 0, 32'hFFFF_8001, 1, 5'd10, 0, 3));
        add_vec("lhu_hi", mi(32'h1002, 0, 32'h8001_7FFF, 1, 0, 3'b101, 1, 5'd11, 0), 0, 1, 0,
                mo(1, 32'h1000, 0, 0, 0, 32'h0000_8001, 1, 5'd11, 0, 3));
        add_vec("sb_lane1", mi(32'h4001, 32'h0000_00A5, 0, 0, 1, 3'b000, 1, 5'd12, 0), 0, 1, 0,
                mo(1, 32'h4000, 1, 32'hA5A5_A5A5, 4'b0010, 32'h4001, 0, 5'd12, 0, 2));
        add_vec("sw", mi(32'h5000, 32'hDEAD_BEEF, 0, 0, 1, 3'b010, 1, 5'd13, 0), 1, 1, 1,
                mo(2, 32'h5000, 1, 32'hDEAD_BEEF, 4'b1111, 32'h5000, 0, 5'd13, 0, 3));
        add_vec("rd_and_wr", mi(32'h6004, 32'h1122_3344, 0, 1, 1, 3'b010, 1, 5'd14, 0), 0, 1, 0,
                mo(1, 32'h6004, 1, 32'h1122_3344, 4'b1111, 32'h6004, 0, 5'd14, 0, 2));
        add_vec("ld_f3_011", mi(32'h7000, 0, 32'hCAFE_BABE, 1, 0, 3'b011, 1, 5'd15, 0), 2, 2, 0,
                mo(3, 32'h7000, 0, 0, 0, 32'hCAFE_BABE, 1, 5'd15, 0, 6));
        add_vec("ld_f3_110_mis", mi(32'h7002, 0, 0, 1, 0, 3'b110, 1, 5'd16, 0), 0, 1, 0,
                mo(0, 0, 0, 0, 0, 32'h7002, 0, 5'd16, 1, 1));
        add_vec("sh_mis", mi(32'h2001, 32'h5555, 0, 0, 1, 3'b001, 1, 5'd17, 0), 0, 1, 0,
                mo(0, 0, 0, 0, 0, 32'h2001, 0, 5'd17, 1, 1));
        add_vec("lb_rv_with_gnt", mi(32'h8000, 0, 32'h0000_007F, 1, 0, 3'b000, 1, 5'd18, 1),
                0, 2, 0, mo(1, 32'h8000, 0, 0, 0, 32'h0000_007F, 1, 5'd18, 0, 4));
        add_vec("nonmem_norw", mi(32'hFFFF_FFFF, 0, 0, 0, 0, 3'b000, 0, 5'd31, 0), 0, 1, 2,
                mo(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 5'd31, 0, 1));
        add_vec("lh_lo", mi(32'h1000, 0, 32'h1234_F00D, 1, 0, 3'b001, 1, 5'd1, 0), 1, 3, 0,
                mo(2, 32'h1000, 0, 0, 0, 32'hFFFF_F00D, 1, 5'd1, 0, 6));

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst.ex_ready", 64'(bus.ex_ready), 64'd1);
        check("rst.mem_req", 64'(bus.mem_req), 64'd0);
        check("rst.wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst.WBData", 64'(bus.WBData), 64'd0);
        check("rst.RegWrite_out", 64'(bus.RegWrite_out), 64'd0);
        check("rst.Misalign", 64'(bus.Misalign), 64'd0);
        check("rst.mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[n]) begin
            run_instr(vecs[n].name, vecs[n].ins, vecs[n].gd, vecs[n].rv, vecs[n].wbd, got);
            compare_obs(vecs[n].name, got, vecs[n].exp);
        end

        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int n = 0; n < 150; n++) begin
            int kind;
            int gd;
            int rv;
            int wbd;
            kind     = int'($urandom_range(0, 3));
            r.alu    = $urandom;
            r.rd2    = $urandom;
            r.rdata  = $urandom;
            r.mr     = (kind == 1 || kind == 3);
            r.mw     = (kind == 2 || kind == 3);
            r.f3     = codes[$urandom_range(0, 7)];
            r.rw     = 1'($urandom);
            r.rd     = 5'($urandom);
            r.rvg    = 1'($urandom);
            gd       = int'($urandom_range(0, 3));
            rv       = int'($urandom_range(1, 3));
            wbd      = int'($urandom_range(0, 2));
            exp = model(r, gd, rv);
            run_instr($sformatf("rand%0d", n), r, gd, rv, wbd, got);
            compare_obs($sformatf("rand%0d", n), got, exp);
        end

        // Asynchronous reset while the request is outstanding: mem_req must drop at once.
        bus.ex_valid = 1'b1; bus.ALUResult = 32'h9000; bus.RD2 = 32'h1;
        bus.MemRead = 1'b0; bus.MemWrite = 1'b1; bus.Funct3 = 3'b010; bus.RegWrite_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid = 1'b0; bus.MemWrite = 1'b0;
        check("rstreq.mem_req_before", 64'(bus.mem_req), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("rstreq.mem_req_drop", 64'(bus.mem_req), 64'd0);
        check("rstreq.ex_ready", 64'(bus.ex_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Asynchronous reset while waiting for read data; a late rvalid must be ignored.
        bus.ex_valid = 1'b1; bus.ALUResult = 32'hA000; bus.MemRead = 1'b1;
        bus.Funct3 = 3'b010; bus.RegWrite_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ex_valid = 1'b0; bus.MemRead = 1'b0;
        bus.mem_gnt  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("rstresp.in_resp_ex_ready", 64'(bus.ex_ready), 64'd0);
        #2 rstn = 1'b0;
        #1;
        check("rstresp.mem_req", 64'(bus.mem_req), 64'd0);
        check("rstresp.wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rstresp.ex_ready", 64'(bus.ex_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        saw_wb = 1'b0;
        repeat (3) begin
            if (bus.wb_valid || !bus.ex_ready) saw_wb = 1'b1;
            @(negedge clk);
        end
        check("rstresp.late_rvalid_ignored", 64'(saw_wb), 64'd0);

        // Stage is usable again after reset.
        run_instr("post_rst", mi(32'h42, 0, 0, 0, 0, 3'b000, 1, 5'd2, 0), 0, 1, 0, got);
        compare_obs("post_rst", got, mo(0, 0, 0, 0, 0, 32'h42, 1, 5'd2, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
